// File: rtl/csnc_enc_param.sv
// ---------------------------------------------------------------------------
// csnc_enc_param -- parametrised cyclic-shift network-coding encoder.
//
// Collects one generation of K source packets (L bits each). Each packet is
// lifted to P = L+1 bits by prepending its even-parity bit. The encoder then
// emits N coded beats: K systematic beats (the lifted packets), followed by
// N-K parity words. Parity j is the XOR over i of the lifted packet i rotated
// left by (i*j*SHIFT_STRIDE) mod P.
//
// Optional feature macro: CSNC_STATS_EN (adds gen_count / err_count outputs).
//
// Ports
//   aclk           in   clock
//   areset         in   synchronous active-high reset
//   s_axis_tdata   in   [L-1:0] source packet
//   s_axis_tvalid  in   source valid
//   s_axis_tready  out  source ready (high only while collecting, low in reset)
//   s_axis_tlast   in   marks last packet of the generation
//   m_axis_tdata   out  [P-1:0] coded beat
//   m_axis_tuser   out  [$clog2(N)-1:0] role index (0..K-1 systematic, K..N-1 parity)
//   m_axis_tvalid  out  coded valid
//   m_axis_tready  in   coded ready
//   m_axis_tlast   out  high on beat N-1
//   err_tlast      out  1-cycle pulse after a generation closed with a tlast mismatch
//   gen_count      out  [31:0] generations fully emitted (CSNC_STATS_EN only, wraps)
//   err_count      out  [15:0] err_tlast pulses (CSNC_STATS_EN only, saturates)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. Once m_axis_tvalid is high, tdata/tuser/tlast are held stable
// until the transfer completes; s_axis_tready does not depend on s_axis_tvalid.
// ---------------------------------------------------------------------------
module csnc_enc_param #(
    parameter int K            = 3,
    parameter int N            = 5,
    parameter int L            = 11,
    parameter int SHIFT_STRIDE = 1
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [L-1:0]         s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [L:0]           m_axis_tdata,
    output logic [$clog2(N)-1:0] m_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 err_tlast
`ifdef CSNC_STATS_EN
    ,
    output logic [31:0]          gen_count,
    output logic [15:0]          err_count
`endif
);

    localparam int P  = L + 1;
    localparam int TW = $clog2(N);
    localparam int CW = $clog2(K);
    localparam int R  = N - K;

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_EMIT    = 1'b1;

    logic [0:0]    state_q;
    logic [CW-1:0] in_cnt_q;
    logic [TW-1:0] out_cnt_q;
    logic [P-1:0]  pkt_buf_q [K];
    logic [P-1:0]  acc_q     [R];
    logic          err_q;

    logic [P-1:0]  lifted;
    logic          last_slot;
    logic          tlast_err;
    logic [P-1:0]  emit_word;

    function automatic logic [P-1:0] lift(input logic [L-1:0] x);
        return {^x, x};
    endfunction

    // Left rotate: the upper half of the doubled word shifted by r.
    function automatic logic [P-1:0] rotl(input logic [P-1:0] w, input int r);
        logic [2*P-1:0] d;
        d = {w, w} << r;
        return d[2*P-1:P];
    endfunction

    assign lifted    = lift(s_axis_tdata);
    assign last_slot = (in_cnt_q == CW'(K - 1));
    // Mismatch: tlast before slot K-1, or slot K-1 reached without tlast.
    assign tlast_err = (s_axis_tlast != last_slot);

    always_comb begin
        emit_word = '0;
        for (int i = 0; i < K; i++) begin
            if (out_cnt_q == TW'(i)) emit_word = pkt_buf_q[i];
        end
        for (int j = 0; j < R; j++) begin
            if (out_cnt_q == TW'(K + j)) emit_word = acc_q[j];
        end
    end

    assign s_axis_tready = (state_q == ST_COLLECT) && !areset;
    assign m_axis_tvalid = (state_q == ST_EMIT);
    assign m_axis_tdata  = m_axis_tvalid ? emit_word : '0;
    assign m_axis_tuser  = m_axis_tvalid ? out_cnt_q : '0;
    assign m_axis_tlast  = m_axis_tvalid && (out_cnt_q == TW'(N - 1));
    assign err_tlast     = err_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= ST_COLLECT;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < K; i++) pkt_buf_q[i] <= '0;
            for (int j = 0; j < R; j++) acc_q[j] <= '0;
`ifdef CSNC_STATS_EN
            gen_count <= '0;
            err_count <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_COLLECT: begin
                    if (s_axis_tvalid) begin
                        // Rotation amounts are constants per (slot, parity) pair,
                        // so only the slot select is data dependent.
                        for (int i = 0; i < K; i++) begin
                            if (in_cnt_q == CW'(i)) begin
                                pkt_buf_q[i] <= lifted;
                                for (int j = 0; j < R; j++) begin
                                    acc_q[j] <= acc_q[j] ^ rotl(lifted, (i * j * SHIFT_STRIDE) % P);
                                end
                            end
                        end
                        in_cnt_q <= in_cnt_q + 1'b1;
                        if (last_slot || s_axis_tlast) begin
                            state_q <= ST_EMIT;
                            err_q   <= tlast_err;
`ifdef CSNC_STATS_EN
                            if (tlast_err && (err_count != 16'hFFFF)) err_count <= err_count + 1'b1;
`endif
                        end
                    end
                end
                ST_EMIT: begin
                    if (m_axis_tready) begin
                        if (out_cnt_q == TW'(N - 1)) begin
                            // Generation done: clear everything so the next one
                            // starts from a clean accumulator.
                            state_q   <= ST_COLLECT;
                            in_cnt_q  <= '0;
                            out_cnt_q <= '0;
                            for (int i = 0; i < K; i++) pkt_buf_q[i] <= '0;
                            for (int j = 0; j < R; j++) acc_q[j] <= '0;
`ifdef CSNC_STATS_EN
                            gen_count <= gen_count + 1'b1;
`endif
                        end else begin
                            out_cnt_q <= out_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_csnc_enc_param.sv
// ---------------------------------------------------------------------------
// tb_csnc_enc_param -- self-checking bench for csnc_enc_param (K=3 N=5 L=11).
// A behavioural model turns every accepted generation into its expected coded
// beats; a negedge compare process checks valid/ready, beat contents, hold
// under backpressure and err_tlast on every cycle.
// ---------------------------------------------------------------------------
module tb_csnc_enc_param;

  localparam int K     = 3;
  localparam int N     = 5;
  localparam int L     = 11;
  localparam int SHIFT = 1;
  localparam int P     = L + 1;
  localparam int TW    = $clog2(N);
  localparam int EW    = 1 + TW + P;

  typedef logic [L-1:0] gen_t [K];

  // ---------------- clock / reset ----------------
  logic          aclk;
  logic          areset;
  logic [L-1:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [P-1:0]  m_axis_tdata;
  logic [TW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          err_tlast;
`ifdef CSNC_STATS_EN
  logic [31:0]   gen_count;
  logic [15:0]   err_count;
`endif

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  csnc_enc_param #(.K(K), .N(N), .L(L), .SHIFT_STRIDE(SHIFT)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .err_tlast     (err_tlast)
`ifdef CSNC_STATS_EN
    ,
    .gen_count     (gen_count),
    .err_count     (err_count)
`endif
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [L-1:0]  acc_pk[$];
  logic          err_pending = 1'b0;
  int            cyc = 0;
  int            first_in = -1;
  int            last_out = -1;
  logic          arm = 1'b0;
  logic          rand_ready = 1'b0;
  int            gen_exp = 0;
  int            err_exp = 0;
  gen_t          mon_g;
  logic [EW-1:0] mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [P-1:0] m_lift(input logic [L-1:0] x);
    int ones = 0;
    for (int b = 0; b < L; b++) ones += int'(x[b]);
    return {ones[0], x};
  endfunction

  function automatic logic [P-1:0] m_rotl(input logic [P-1:0] w, input int r);
    logic [P-1:0] o = '0;
    for (int b = 0; b < P; b++) o[(b + r) % P] = w[b];
    return o;
  endfunction

  function automatic logic [P-1:0] m_beat(input gen_t g, input int idx);
    logic [P-1:0] a = '0;
    if (idx < K) return m_lift(g[idx]);
    for (int i = 0; i < K; i++) a ^= m_rotl(m_lift(g[i]), (i * (idx - K) * SHIFT) % P);
    return a;
  endfunction

  // ---------------- output ready driver ----------------
  initial m_axis_tready = 1'b1;
  always @(posedge aclk) begin
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- compare process ----------------
  always @(negedge aclk) begin
    cyc++;
    if (areset) begin
      check("tready_in_reset", 32'(s_axis_tready), 32'(0));
      exp_q.delete();
      acc_pk.delete();
      err_pending = 1'b0;
      gen_exp = 0;
      err_exp = 0;
    end else begin
      check("err_tlast", 32'(err_tlast), 32'(err_pending));
      err_pending = 1'b0;
      check("m_tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
      check("s_tready", 32'(s_axis_tready), 32'(exp_q.size() == 0));
      if (m_axis_tvalid && exp_q.size() != 0) begin
        // Compared every valid cycle, so stalled beats must hold the front entry.
        mon_w = exp_q[0];
        check("m_tdata", 32'(m_axis_tdata), 32'(mon_w[P-1:0]));
        check("m_tuser", 32'(m_axis_tuser), 32'(mon_w[P+TW-1:P]));
        check("m_tlast", 32'(m_axis_tlast), 32'(mon_w[EW-1]));
        if (m_axis_tready) begin
          void'(exp_q.pop_front());
          last_out = cyc;
          if (mon_w[EW-1]) gen_exp++;
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        if (arm && first_in < 0) first_in = cyc;
        acc_pk.push_back(s_axis_tdata);
        if (acc_pk.size() == K || s_axis_tlast) begin
          for (int i = 0; i < K; i++) mon_g[i] = (i < acc_pk.size()) ? acc_pk[i] : '0;
          err_pending = (s_axis_tlast != (acc_pk.size() == K));
          if (err_pending) err_exp++;
          for (int b = 0; b < N; b++) exp_q.push_back({b == N - 1, TW'(b), m_beat(mon_g, b)});
          acc_pk.delete();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pkt(input logic [L-1:0] d, input logic last);
    int t = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_tready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (!s_axis_tready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: s_axis_tready got 0 expected 1 within 200 cycles");
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_gen(input logic [L-1:0] d0, input logic [L-1:0] d1, input logic [L-1:0] d2);
    send_pkt(d0, 1'b0);
    send_pkt(d1, 1'b0);
    send_pkt(d2, 1'b1);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge aclk);
    #1;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge aclk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d beats outstanding expected 0", exp_q.size());
    end
    @(posedge aclk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    gen_t g;
    areset        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;

    // Pin the model against hand-computed values.
    g = '{11'h001, 11'h000, 11'h000};
    check("model_d0_b0", 32'(m_beat(g, 0)), 32'h801);
    check("model_d0_b1", 32'(m_beat(g, 1)), 32'h000);
    check("model_d0_p0", 32'(m_beat(g, 3)), 32'h801);
    check("model_d0_p1", 32'(m_beat(g, 4)), 32'h801);
    g = '{11'h000, 11'h001, 11'h000};
    check("model_d1_p0", 32'(m_beat(g, 3)), 32'h801);
    check("model_d1_p1", 32'(m_beat(g, 4)), 32'h003);
    g = '{11'h000, 11'h000, 11'h001};
    check("model_d2_p0", 32'(m_beat(g, 3)), 32'h801);
    check("model_d2_p1", 32'(m_beat(g, 4)), 32'h006);
    g = '{11'h003, 11'h000, 11'h000};
    check("model_even_lift", 32'(m_beat(g, 0)), 32'h003);

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'(0));
    check("rst_m_tdata", 32'(m_axis_tdata), 32'(0));
    check("rst_m_tuser", 32'(m_axis_tuser), 32'(0));
    check("rst_m_tlast", 32'(m_axis_tlast), 32'(0));
    check("rst_err", 32'(err_tlast), 32'(0));
    check("rst_s_tready", 32'(s_axis_tready), 32'(0));
`ifdef CSNC_STATS_EN
    check("rst_gen_count", gen_count, 32'(0));
    check("rst_err_count", 32'(err_count), 32'(0));
`endif
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Directed single-bit generations.
    send_gen(11'h001, 11'h000, 11'h000);
    wait_idle();
    send_gen(11'h000, 11'h001, 11'h000);
    wait_idle();
    send_gen(11'h000, 11'h000, 11'h001);
    wait_idle();

    // Random data with random output backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      send_gen(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
               11'($urandom_range(0, 2047)));
      wait_idle();
    end
    rand_ready = 1'b0;

    // Early tlast on d1, then a clean generation.
    send_pkt(11'h155, 1'b0);
    send_pkt(11'h2AA, 1'b1);
    wait_idle();
    send_gen(11'h7FF, 11'h123, 11'h456);
    wait_idle();
`ifdef CSNC_STATS_EN
    check("err_count_early", 32'(err_count), 32'(err_exp));
`endif

    // Missing tlast on beat K-1.
    send_pkt(11'h0F0, 1'b0);
    send_pkt(11'h00F, 1'b0);
    send_pkt(11'h3C3, 1'b0);
    wait_idle();

    // Reset after two input beats: nothing emitted, no stale XOR terms.
    send_pkt(11'h5A5, 1'b0);
    send_pkt(11'h1E1, 1'b0);
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    repeat (6) @(posedge aclk);
    #1;
    send_gen(11'h001, 11'h002, 11'h004);
    wait_idle();

    // Four generations back to back with tready=1.
    arm = 1'b1;
    first_in = -1;
    for (int n = 0; n < 4; n++) begin
      send_pkt(11'($urandom_range(0, 2047)), 1'b0);
      send_pkt(11'($urandom_range(0, 2047)), 1'b0);
      send_pkt(11'($urandom_range(0, 2047)), 1'b1);
    end
    wait_idle();
    arm = 1'b0;
    check("b2b_cycles", 32'(last_out - first_in + 1), 32'(4 * (K + N)));
`ifdef CSNC_STATS_EN
    check("gen_count", gen_count, 32'(gen_exp));
    check("err_count", 32'(err_count), 32'(err_exp));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
